// File: rtl/mux_select_sequencer.sv
// Steps the 4:1 mux select through enabled channels, settles, samples f.
// Define MUX_SEQ_ONESHOT_EN for one sweep per rising edge of en.
module mux_select_sequencer #(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         chan_mask,
    input  logic               f_in,
    output logic               s1,
    output logic               s0,
    output logic [3:0]         f_sample,
    output logic               sample_valid,
    output logic               sweep_done,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_NEXT
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [3:0]         r_fs;
    logic               r_sv;
    logic               r_sd;
    logic               r_busy;
    logic [3:0]         r_settle_cnt;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic [1:0]         w_low;
    logic [1:0]         w_nxt;
    logic [1:0]         w_idx;
    logic               w_wrap;
    logic               w_start;

`ifdef MUX_SEQ_ONESHOT_EN
    logic               r_en_d;
    assign w_start = en && !r_en_d;
`else
    assign w_start = en;
`endif

    // Nearest set bit above r_sel wins; offset 4 lands back on r_sel itself.
    always_comb begin
        w_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (chan_mask[i]) w_low = 2'(i);
        end
        w_idx = 2'd0;
        w_nxt = r_sel;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_sel + 2'(k);
            if (chan_mask[w_idx]) w_nxt = w_idx;
        end
        w_wrap = (w_nxt <= r_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= 2'd0;
            r_fs         <= 4'd0;
            r_sv         <= 1'b0;
            r_sd         <= 1'b0;
            r_busy       <= 1'b0;
            r_settle_cnt <= 4'd0;
            r_dwell_cnt  <= '0;
`ifdef MUX_SEQ_ONESHOT_EN
            r_en_d       <= 1'b0;
`endif
        end else begin
            r_sv <= 1'b0;
            r_sd <= 1'b0;
`ifdef MUX_SEQ_ONESHOT_EN
            r_en_d <= en;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_start && (chan_mask != 4'd0)) begin
                        r_sel        <= w_low;
                        r_settle_cnt <= 4'd0;
                        r_state      <= ST_SETTLE;
                        r_busy       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_fs[r_sel] <= f_in;
                        r_sv        <= 1'b1;
                        r_dwell_cnt <= dwell;
                        r_state     <= (dwell == '0) ? ST_NEXT : ST_DWELL;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                ST_DWELL: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_dwell_cnt <= DWELL_W'(1)) begin
                        r_state <= ST_NEXT;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (!en || (chan_mask == 4'd0)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sel        <= w_nxt;
                        r_sd         <= w_wrap;
                        r_settle_cnt <= 4'd0;
`ifdef MUX_SEQ_ONESHOT_EN
                        r_state <= w_wrap ? ST_IDLE : ST_SETTLE;
                        r_busy  <= !w_wrap;
`else
                        r_state <= ST_SETTLE;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s1           = r_sel[1];
    assign s0           = r_sel[0];
    assign f_sample     = r_fs;
    assign sample_valid = r_sv;
    assign sweep_done   = r_sd;
    assign busy         = r_busy;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: cycle tables plus swept periods.
// Expects the default build (MUX_SEQ_ONESHOT_EN adds a one-shot section).
module tb_mux_select_sequencer;

    localparam int SETTLE = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] dwell;
    logic [3:0] chan_mask;
    logic       f_in;
    logic       s1;
    logic       s0;
    logic [3:0] f_sample;
    logic       sample_valid;
    logic       sweep_done;
    logic       busy;

    logic [3:0] data;
    logic [3:0] exp_fs;
    int         errors;
    int         checks;

    mux_select_sequencer #(
        .DWELL_W(8),
        .SETTLE (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .dwell       (dwell),
        .chan_mask   (chan_mask),
        .f_in        (f_in),
        .s1          (s1),
        .s0          (s0),
        .f_sample    (f_sample),
        .sample_valid(sample_valid),
        .sweep_done  (sweep_done),
        .busy        (busy)
    );

    // The mux being driven: f reflects the data bit of the selected channel.
    assign f_in = data[{s1, s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [7:0] dwell;
        logic [3:0] mask;
        logic [3:0] data;
        logic [1:0] sel;
        logic [3:0] fs;
        logic       sv;
        logic       sd;
        logic       busy;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h expected=%0h", nm, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_fs = 4'd0;
    endtask

    task automatic check_all(input int k, input logic [1:0] sel,
                             input logic [3:0] fs, input logic sv,
                             input logic sd, input logic bz);
        chk("sel", k, 32'({s1, s0}), 32'(sel));
        chk("f_sample", k, 32'(f_sample), 32'(fs));
        chk("sample_valid", k, 32'(sample_valid), 32'(sv));
        chk("sweep_done", k, 32'(sweep_done), 32'(sd));
        chk("busy", k, 32'(busy), 32'(bz));
    endtask

    // Channel list packed 2 bits per entry, lowest first; one select per period.
    task automatic sweep(input int n, input int per,
                         input logic [7:0] chans, input int nch);
        int         idx;
        logic [1:0] es;
        logic       esv;
        logic       esd;
        for (int k = 0; k < n; k++) begin
            tick();
            idx = (k / per) % nch;
            es  = chans[2*idx +: 2];
            esv = (k % per == SETTLE);
            esd = (k % per == 0) && (k > 0) && (idx == 0);
            if (esv) exp_fs[es] = data[es];
            check_all(k, es, exp_fs, esv, esd, 1'b1);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        en        = 1'b0;
        dwell     = 8'd0;
        chan_mask = 4'd0;
        data      = 4'd0;
        exp_fs    = 4'd0;
        rst_n     = 1'b0;

        tbl[0]  = '{1'b1, 8'd3, 4'hF, 4'b1011, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 8'd3, 4'hF, 4'b1011, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'd3, 4'hF, 4'b1011, 2'd0, 4'b0001, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'd1, 4'h1, 4'b1011, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 8'd1, 4'h1, 4'b1011, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'd1, 4'h1, 4'b1011, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'd3, 4'hF, 4'b1011, 2'd1, 4'b0001, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'd3, 4'hF, 4'b1011, 2'd1, 4'b0001, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'd3, 4'hF, 4'b1011, 2'd1, 4'b0011, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'd3, 4'hF, 4'b1011, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'd3, 4'hF, 4'b1011, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'd3, 4'hF, 4'b1011, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'd3, 4'hF, 4'b1010, 2'd0, 4'b0011, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 8'd3, 4'hF, 4'b1010, 2'd0, 4'b0011, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'd3, 4'hF, 4'b1010, 2'd0, 4'b0011, 1'b0, 1'b0, 1'b0};

        #1;
        check_all(-1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Four channels, dwell 3: period 6, wrap 3->0 pulses sweep_done.
        do_reset();
        dwell = 8'd3; chan_mask = 4'hF; data = 4'b0110; en = 1'b1;
        sweep(26, 6, 8'b11_10_01_00, 4);

        // Channels 1 and 3 alternate; ends early in a SETTLE phase.
        do_reset();
        dwell = 8'd3; chan_mask = 4'b1010; data = 4'b0010; en = 1'b1;
        sweep(25, 6, 8'b00_00_11_01, 2);
        chk("fs_1010", 0, 32'(f_sample), 32'h2);

        // Asynchronous reset mid-SETTLE, no clock edge involved.
        #3;
        rst_n = 1'b0;
        #1;
        check_all(100, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_fs = 4'd0;
        chan_mask = 4'b1100;
        tick();
        check_all(101, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1);

        // Single channel, no dwell: period 3, valid and done alternate.
        do_reset();
        dwell = 8'd0; chan_mask = 4'b0100; data = 4'b0100; en = 1'b1;
        sweep(12, 3, 8'b00_00_00_10, 1);

        // Cycle table: latched dwell, late mask change, en drop, abandoned capture.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            en        = tbl[i].en;
            dwell     = tbl[i].dwell;
            chan_mask = tbl[i].mask;
            data      = tbl[i].data;
            tick();
            check_all(200 + i, tbl[i].sel, tbl[i].fs, tbl[i].sv,
                      tbl[i].sd, tbl[i].busy);
        end

`ifdef MUX_SEQ_ONESHOT_EN
        do_reset();
        dwell = 8'd0; chan_mask = 4'hF; data = 4'b0000; en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            if (k == 12) check_all(300, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("oneshot_hold", k, 32'(busy), 32'd0);
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        check_all(301, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
